spi_master_word_reader: RTL



---
 rtl/spi_master_pkg.sv | 31 +++
 rtl/spi_master_word_reader_timer.sv | 27 ++
 rtl/spi_master_word_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and default timing constants for the SPI word reader.
// All timing parameters are counted in system clock cycles.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SCLK_LOW,
    ST_SCLK_HIGH,
    ST_WAIT_OUT,
    ST_CS_HOLD
  } state_t;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_HALF_PERIOD     = 4;
  localparam int DEFAULT_CS_SETUP_CYCLES = 2;
  localparam int DEFAULT_CS_HOLD_CYCLES  = 2;
  localparam int WORD_COUNT_WIDTH        = 8;
  localparam int TIMER_WIDTH             = 8;

  // A count field of zero encodes the maximum burst length.
  function automatic logic [WORD_COUNT_WIDTH:0] burst_length(
    input logic [WORD_COUNT_WIDTH-1:0] count
  );
    if (count == '0) begin
      return {1'b1, {WORD_COUNT_WIDTH{1'b0}}};
    end
    return {1'b0, count};
  endfunction

endpackage

// File: rtl/spi_master_word_reader_timer.sv
// Loadable down-counter; terminal is high while the count sits at zero.
// Loading N-1 on entry to a state gives a state duration of N cycles.
module spi_half_period_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign terminal = (count_reg == '0);

endmodule

// File: rtl/spi_master_word_reader.sv
// Mode-0 SPI master that reads bursts of MSB-first words from a slave and
// delivers them on a valid/ready stream; a full output slot stalls serial_clock.
module spi_master_word_reader
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int HALF_PERIOD     = DEFAULT_HALF_PERIOD,
  parameter int CS_SETUP_CYCLES = DEFAULT_CS_SETUP_CYCLES,
  parameter int CS_HOLD_CYCLES  = DEFAULT_CS_HOLD_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        request_valid,
  output logic                        request_ready,
  input  logic [WORD_COUNT_WIDTH-1:0] request_word_count,
  input  logic                        abort,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic [DATA_WIDTH-1:0]       data,
  output logic                        busy,
  output logic                        serial_clock,
  output logic                        chip_select,
  input  logic                        serial_in
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [TIMER_WIDTH-1:0] SETUP_LOAD = TIMER_WIDTH'(CS_SETUP_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] HALF_LOAD  = TIMER_WIDTH'(HALF_PERIOD - 1);
  localparam logic [TIMER_WIDTH-1:0] HOLD_LOAD  = TIMER_WIDTH'(CS_HOLD_CYCLES - 1);

  state_t                      state_reg, state_next;
  logic                        chip_select_reg, chip_select_next;
  logic                        serial_clock_reg, serial_clock_next;
  logic [DATA_WIDTH-1:0]       shift_reg, shift_next;
  logic [DATA_WIDTH-1:0]       data_reg, data_next;
  logic                        data_valid_reg, data_valid_next;
  logic [BIT_W-1:0]            bit_count_reg, bit_count_next;
  logic [WORD_COUNT_WIDTH:0]   words_reg, words_next;
  logic                        timer_load;
  logic [TIMER_WIDTH-1:0]      timer_value;
  logic                        timer_done;
  logic                        slot_free;
  logic                        deliver;
  logic                        enter_hold;

  spi_half_period_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .terminal   (timer_done)
  );

  assign slot_free = !data_valid_reg || data_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      chip_select_reg  <= 1'b1;
      serial_clock_reg <= 1'b0;
      shift_reg        <= '0;
      data_reg         <= '0;
      data_valid_reg   <= 1'b0;
      bit_count_reg    <= '0;
      words_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      chip_select_reg  <= chip_select_next;
      serial_clock_reg <= serial_clock_next;
      shift_reg        <= shift_next;
      data_reg         <= data_next;
      data_valid_reg   <= data_valid_next;
      bit_count_reg    <= bit_count_next;
      words_reg        <= words_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    chip_select_next  = chip_select_reg;
    serial_clock_next = serial_clock_reg;
    shift_next        = shift_reg;
    data_next         = data_reg;
    data_valid_next   = data_valid_reg && !data_ready;
    bit_count_next    = bit_count_reg;
    words_next        = words_reg;
    timer_load        = 1'b0;
    timer_value       = '0;
    deliver           = 1'b0;
    enter_hold        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (request_valid) begin
          words_next       = burst_length(request_word_count);
          chip_select_next = 1'b0;
          state_next       = ST_CS_SETUP;
          timer_load       = 1'b1;
          timer_value      = SETUP_LOAD;
        end
      end
      ST_CS_SETUP: begin
        if (abort) begin
          enter_hold = 1'b1;
        end else if (timer_done) begin
          state_next  = ST_SCLK_LOW;
          timer_load  = 1'b1;
          timer_value = HALF_LOAD;
        end
      end
      ST_SCLK_LOW: begin
        if (abort) begin
          enter_hold = 1'b1;
        end else if (timer_done) begin
          shift_next        = {shift_reg[DATA_WIDTH-2:0], serial_in};
          serial_clock_next = 1'b1;
          bit_count_next    = bit_count_reg + 1'b1;
          state_next        = ST_SCLK_HIGH;
          timer_load        = 1'b1;
          timer_value       = HALF_LOAD;
        end
      end
      ST_SCLK_HIGH: begin
        if (abort) begin
          enter_hold = 1'b1;
        end else if (timer_done) begin
          serial_clock_next = 1'b0;
          if (bit_count_reg < BIT_W'(DATA_WIDTH)) begin
            state_next  = ST_SCLK_LOW;
            timer_load  = 1'b1;
            timer_value = HALF_LOAD;
          end else if (slot_free) begin
            deliver = 1'b1;
          end else begin
            state_next = ST_WAIT_OUT;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (abort) begin
          enter_hold = 1'b1;
        end else if (slot_free) begin
          deliver = 1'b1;
        end
      end
      ST_CS_HOLD: begin
        if (timer_done) begin
          chip_select_next = 1'b1;
          state_next       = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A completed word moves into the output slot and the burst either
    // continues with the next bit or winds down through the hold phase.
    if (deliver) begin
      data_next       = shift_reg;
      data_valid_next = 1'b1;
      words_next      = words_reg - 1'b1;
      bit_count_next  = '0;
      timer_load      = 1'b1;
      if (words_reg > (WORD_COUNT_WIDTH+1)'(1)) begin
        state_next  = ST_SCLK_LOW;
        timer_value = HALF_LOAD;
      end else begin
        state_next  = ST_CS_HOLD;
        timer_value = HOLD_LOAD;
      end
    end

    if (enter_hold) begin
      serial_clock_next = 1'b0;
      bit_count_next    = '0;
      state_next        = ST_CS_HOLD;
      timer_load        = 1'b1;
      timer_value       = HOLD_LOAD;
    end
  end

  assign request_ready = (state_reg == ST_IDLE);
  assign busy          = (state_reg != ST_IDLE);
  assign data_valid    = data_valid_reg;
  assign data          = data_reg;
  assign serial_clock  = serial_clock_reg;
  assign chip_select   = chip_select_reg;

endmodule
